lfsr_step_sequencer: RTL and testbench
======================================

// Module: lfsr_step_sequencer
// PURPOSE
//  Command-driven sequencer for the 14-bit Sierpinski/LFSR generator core.
//  Owns the generator's seed-load and step strobes, paces steps with a fixed divider,
//  and streams each new 14-bit state out over a valid/ready port with backpressure.
//  Sits between the tt_um_ top-level I/O decode and the generator datapath.
// PARAMETERS
//  WIDTH        14       generator state width
//  STEP_DIV     4        idle cycles in WAIT before each step (legal range >= 1)
//  DEFAULT_SEED 14'h0001 seed substituted when a zero seed is loaded
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous reset, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      command accepted when cmd_valid & cmd_ready at clk edge
//  cmd_op     in   2      0=LOAD_SEED 1=RUN_N 2=FREE_RUN 3=STOP
//  cmd_arg    in   WIDTH  seed (LOAD_SEED) or step count (RUN_N); ignored otherwise
//  gen_load   out  1      1-cycle strobe: generator loads gen_seed
//  gen_seed   out  WIDTH  seed value, valid while gen_load=1
//  gen_step   out  1      1-cycle strobe: generator advances one state
//  gen_state  in   WIDTH  current generator state
//  out_valid  out  1      out_data holds a new state
//  out_ready  in   1      consumer accepts out_data
//  out_data   out  WIDTH  gen_state while out_valid=1, else 0
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse at end of RUN_N or STOP
//  cmd_err    out  1      1-cycle pulse: command consumed but dropped
//  step_cnt   out  16     total completed steps since reset, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except cmd_ready=1; remaining=0; step_cnt=0.
//  FSM: IDLE, LOAD, WAIT, STEP, PRESENT.
//   IDLE: cmd_ready=1. LOAD_SEED -> LOAD. RUN_N arg=0 -> stay IDLE, done=1 next cycle.
//     RUN_N arg>0 -> remaining=arg, free=0, WAIT. FREE_RUN -> free=1, WAIT.
//     STOP in IDLE -> no action, no done, no err.
//   LOAD: exactly 1 cycle; gen_load=1, gen_seed=(arg==0 ? DEFAULT_SEED : arg); cmd_ready=0;
//     -> IDLE.
//   WAIT: STEP_DIV cycles (counter), then -> STEP.
//   STEP: exactly 1 cycle, gen_step=1; -> PRESENT.
//   PRESENT: out_valid=1 until out_valid&out_ready at an edge; that edge increments
//     step_cnt, decrements remaining (RUN_N); then: free or remaining!=0 -> WAIT,
//     else -> IDLE with done=1 next cycle.
//  Active-state commands (LOAD..PRESENT except LOAD): cmd_ready=1.
//   STOP: sets stop_pend. In WAIT -> IDLE next cycle (no gen_step), done=1.
//     In STEP/PRESENT the in-flight output still completes its handshake,
//     then -> IDLE, done=1. out_valid never drops without a handshake.
//   LOAD_SEED/RUN_N/FREE_RUN while active: consumed, ignored, cmd_err=1 next cycle.
//  Latency: RUN_N accepted at edge T -> gen_step high in cycle T+STEP_DIV+1,
//   out_valid high from cycle T+STEP_DIV+2. Min step period with out_ready=1:
//   STEP_DIV+2 cycles.
//  gen_step never asserted while out_valid=1, so out_data is stable during PRESENT.
//  Simultaneous final handshake and STOP: single done pulse, -> IDLE.
//  rst asserted mid-run: returns to reset state next edge; pending output is discarded.
// TESTING
//  1 Reset: rst=1 2 cycles -> out_valid=0,busy=0,cmd_ready=1,step_cnt=0.
//  2 LOAD_SEED arg=0 -> gen_load 1 cycle with gen_seed=14'h0001; arg=14'h1A5 -> 14'h1A5.
//  3 RUN_N arg=3, out_ready=1, STEP_DIV=4 -> exactly 3 gen_step pulses 6 cycles apart,
//    first at accept+5; 3 out handshakes; done once; step_cnt=3.
//  4 RUN_N arg=2, out_ready=0 for 10 cycles -> out_valid held, out_data stable,
//    no second gen_step until ready=1.
//  5 FREE_RUN then STOP during PRESENT with out_ready=0 -> waits for handshake, done=1,
//    IDLE; STOP in WAIT -> no further gen_step.
//  6 RUN_N arg=0 -> done next cycle, no gen_step; RUN_N while busy -> cmd_err pulse,
//    run unaffected.

Source files
------------

// File: rtl/lfsr_step_sequencer.sv
// Command sequencer for the 14-bit LFSR generator: loads seeds, paces steps with a
// fixed divider and streams each new generator state over a valid/ready port.
module lfsr_step_sequencer #(
    parameter int               WIDTH        = 14,
    parameter int               STEP_DIV     = 4,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 14'h0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             gen_load,
    output logic [WIDTH-1:0] gen_seed,
    output logic             gen_step,
    input  logic [WIDTH-1:0] gen_state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             cmd_err,
    output logic [15:0]      step_cnt
);

    localparam logic [1:0] OP_LOAD_SEED = 2'd0;
    localparam logic [1:0] OP_RUN_N     = 2'd1;
    localparam logic [1:0] OP_FREE_RUN  = 2'd2;
    localparam logic [1:0] OP_STOP      = 2'd3;

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(STEP_DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, STEP, PRESENT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] remaining, remaining_n;
    logic [WIDTH-1:0] seed_reg, seed_n;
    logic [CW-1:0]    wait_cnt, wait_n;
    logic [15:0]      cnt_n;
    logic             free_run, free_n;
    logic             stop_pend, stop_n;
    logic             done_n, err_n;
    logic             cmd_fire, stop_cmd, bad_cmd, out_fire, run_over;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            seed_reg  <= '0;
            wait_cnt  <= '0;
            step_cnt  <= '0;
            free_run  <= 1'b0;
            stop_pend <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            seed_reg  <= seed_n;
            wait_cnt  <= wait_n;
            step_cnt  <= cnt_n;
            free_run  <= free_n;
            stop_pend <= stop_n;
            done      <= done_n;
            cmd_err   <= err_n;
        end
    end

    always_comb begin
        cmd_ready = (state != LOAD);
        gen_load  = (state == LOAD);
        gen_seed  = (state == LOAD) ? seed_reg : '0;
        gen_step  = (state == STEP);
        out_valid = (state == PRESENT);
        out_data  = (state == PRESENT) ? gen_state : '0;
        busy      = (state != IDLE);
    end

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        seed_n      = seed_reg;
        wait_n      = wait_cnt;
        cnt_n       = step_cnt;
        free_n      = free_run;
        stop_n      = stop_pend;
        done_n      = 1'b0;
        err_n       = 1'b0;
        cmd_fire    = cmd_valid && cmd_ready;
        stop_cmd    = cmd_fire && (cmd_op == OP_STOP);
        bad_cmd     = cmd_fire && (cmd_op != OP_STOP);
        out_fire    = out_valid && out_ready;
        run_over    = !free_run && (remaining == WIDTH'(1));

        // Any non-STOP command arriving while a run is active is swallowed and flagged.
        if (state == WAIT || state == STEP || state == PRESENT) begin
            err_n = bad_cmd;
        end

        case (state)
            IDLE: begin
                stop_n = 1'b0;
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_LOAD_SEED: begin
                            seed_n  = (cmd_arg == '0) ? DEFAULT_SEED : cmd_arg;
                            state_n = LOAD;
                        end
                        OP_RUN_N: begin
                            if (cmd_arg == '0) begin
                                done_n = 1'b1;
                            end else begin
                                remaining_n = cmd_arg;
                                free_n      = 1'b0;
                                wait_n      = '0;
                                state_n     = WAIT;
                            end
                        end
                        OP_FREE_RUN: begin
                            free_n  = 1'b1;
                            wait_n  = '0;
                            state_n = WAIT;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD: state_n = IDLE;
            WAIT: begin
                // No step is in flight yet, so STOP can end the run right away.
                if (stop_cmd) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    stop_n  = 1'b0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = STEP;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            STEP: begin
                state_n = PRESENT;
                if (stop_cmd) stop_n = 1'b1;
            end
            PRESENT: begin
                if (out_fire) begin
                    cnt_n = step_cnt + 16'd1;
                    if (!free_run) remaining_n = remaining - 1'b1;
                    if (stop_pend || stop_cmd || run_over) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        stop_n  = 1'b0;
                    end else begin
                        state_n = WAIT;
                        wait_n  = '0;
                    end
                end else if (stop_cmd) begin
                    stop_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lfsr_step_sequencer.sv
// Self-checking bench for lfsr_step_sequencer: a behavioural generator plus an event
// monitor; expectations come from command counts, timing rules and the LFSR sequence.
module tb_lfsr_step_sequencer;

    localparam int WIDTH    = 14;
    localparam int STEP_DIV = 4;
    localparam logic [1:0] OP_LOAD = 2'd0, OP_RUN = 2'd1, OP_FREE = 2'd2, OP_STOP = 2'd3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [WIDTH-1:0] cmd_arg = '0;
    logic             gen_load, gen_step;
    logic [WIDTH-1:0] gen_seed, gen_state, out_data;
    logic             out_valid, out_ready;
    logic             busy, done, cmd_err;
    logic [15:0]      step_cnt;

    logic fixed_ready = 1'b1;
    logic rand_en     = 1'b0;
    logic rnd_bit     = 1'b0;
    assign out_ready = rand_en ? rnd_bit : fixed_ready;

    lfsr_step_sequencer #(.WIDTH(WIDTH), .STEP_DIV(STEP_DIV), .DEFAULT_SEED(14'h0001)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .gen_load(gen_load), .gen_seed(gen_seed), .gen_step(gen_step), .gen_state(gen_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .cmd_err(cmd_err), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[12:0], s[13] ^ s[12] ^ s[10] ^ s[0]};
    endfunction

    // Behavioural generator datapath driven by the sequencer's strobes.
    logic [WIDTH-1:0] gen_r = '0;
    assign gen_state = gen_r;
    always @(posedge clk) begin
        if (rst) gen_r <= '0;
        else if (gen_load) gen_r <= gen_seed;
        else if (gen_step) gen_r <= lfsr_next(gen_r);
    end

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int n_load = 0, n_step = 0, n_hs = 0, n_done = 0, n_err = 0, viol = 0;
    int last_seed = 0;
    int step_q[$];
    int hs_q[$];
    logic prev_pend = 1'b0, prev_step = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_pend = 1'b0;
            prev_step = 1'b0;
        end else begin
            if (gen_load) begin n_load++; last_seed = int'(gen_seed); end
            if (gen_step) begin
                n_step++;
                step_q.push_back(cyc);
                if (out_valid) viol++;
            end
            if (prev_step && !out_valid) viol++;
            if (prev_pend && (!out_valid || out_data != prev_data)) viol++;
            if (done) n_done++;
            if (cmd_err) n_err++;
            if (out_valid && out_ready) begin n_hs++; hs_q.push_back(int'(out_data)); end
            prev_pend = out_valid && !out_ready;
            prev_data = out_data;
            prev_step = gen_step;
        end
    end

    int total = 0, bad = 0;
    logic [WIDTH-1:0] model_state = '0;
    int s_load, s_step, s_hs, s_done, s_err, s_cnt;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic snapshot();
        s_load = n_load; s_step = n_step; s_hs = n_hs;
        s_done = n_done; s_err = n_err; s_cnt = int'(step_cnt);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] arg, output int acc);
        int to;
        to = 1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin to = 0; break; end
        end
        checkOutput("cmd_accept_timeout", to, 0);
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle(input int max);
        int to;
        to = 1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy) begin to = 0; break; end
        end
        checkOutput("idle_timeout", to, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic waitValid(input int max);
        int to;
        to = 1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (out_valid) begin to = 0; break; end
        end
        checkOutput("valid_timeout", to, 0);
    endtask

    task automatic checkStream(input string name, input int from_i);
        for (int i = from_i; i < n_hs; i++) begin
            model_state = lfsr_next(model_state);
            checkOutput($sformatf("%s_data%0d", name, i - from_i), hs_q[i], int'(model_state));
        end
    endtask

    task automatic checkRun(input string name, input int steps, input int dn, input int er);
        checkOutput({name, "_steps"}, n_step - s_step, steps);
        checkOutput({name, "_hs"}, n_hs - s_hs, steps);
        checkOutput({name, "_done"}, n_done - s_done, dn);
        checkOutput({name, "_err"}, n_err - s_err, er);
        checkOutput({name, "_stepcnt"}, (int'(step_cnt) - s_cnt) & 16'hFFFF, steps);
        checkOutput({name, "_busy"}, int'(busy), 0);
        checkStream(name, s_hs);
    endtask

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] arg;
        int               exp_load;
        int               exp_seed;
        int               exp_steps;
        int               exp_done;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int acc, hold_data, st0, n;
        logic [WIDTH-1:0] seed;

        vecs[0] = '{OP_LOAD, 14'h0000, 1, 'h0001, 0, 0};
        vecs[1] = '{OP_LOAD, 14'h01A5, 1, 'h01A5, 0, 0};
        vecs[2] = '{OP_STOP, 14'h0007, 0, 0,      0, 0};
        vecs[3] = '{OP_RUN,  14'h0000, 0, 0,      0, 1};
        vecs[4] = '{OP_RUN,  14'h0001, 0, 0,      1, 1};
        vecs[5] = '{OP_LOAD, 14'h3FFF, 1, 'h3FFF, 0, 0};
        vecs[6] = '{OP_RUN,  14'h0002, 0, 0,      2, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_cmd_ready", int'(cmd_ready), 1);
        checkOutput("rst_step_cnt", int'(step_cnt), 0);
        checkOutput("rst_strobes", int'({gen_load, gen_step, done, cmd_err}), 0);

        // Table-driven single commands from IDLE
        fixed_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            snapshot();
            applyStimulus(vecs[v].op, vecs[v].arg, acc);
            waitIdle(100);
            checkOutput($sformatf("vec%0d_load", v), n_load - s_load, vecs[v].exp_load);
            if (vecs[v].exp_load != 0) begin
                checkOutput($sformatf("vec%0d_seed", v), last_seed, vecs[v].exp_seed);
                model_state = WIDTH'(vecs[v].exp_seed);
            end
            checkRun($sformatf("vec%0d", v), vecs[v].exp_steps, vecs[v].exp_done, 0);
        end

        // RUN_N 3 timing: spec cycle k is sampled here at the negedge where cyc == k-1,
        // so the first step (cycle acc+STEP_DIV+1) appears with cyc == acc+STEP_DIV.
        applyStimulus(OP_LOAD, 14'h01A5, acc);
        model_state = 14'h01A5;
        waitIdle(20);
        snapshot();
        st0 = step_q.size();
        applyStimulus(OP_RUN, 14'd3, acc);
        waitIdle(100);
        checkRun("run3", 3, 1, 0);
        if (step_q.size() >= st0 + 3) begin
            checkOutput("run3_first_step", step_q[st0] - acc, STEP_DIV);
            checkOutput("run3_gap1", step_q[st0+1] - step_q[st0], STEP_DIV + 2);
            checkOutput("run3_gap2", step_q[st0+2] - step_q[st0+1], STEP_DIV + 2);
        end

        // Backpressure: out_ready low for 10 cycles
        snapshot();
        fixed_ready = 1'b0;
        applyStimulus(OP_RUN, 14'd2, acc);
        waitValid(50);
        hold_data = int'(out_data);
        repeat (10) @(negedge clk);
        checkOutput("bp_valid_held", int'(out_valid), 1);
        checkOutput("bp_data_stable", int'(out_data), hold_data);
        checkOutput("bp_one_step", n_step - s_step, 1);
        fixed_ready = 1'b1;
        waitIdle(100);
        checkRun("bp", 2, 1, 0);

        // FREE_RUN, STOP during PRESENT with out_ready low
        snapshot();
        fixed_ready = 1'b0;
        applyStimulus(OP_FREE, 14'd0, acc);
        waitValid(50);
        applyStimulus(OP_STOP, 14'd0, acc);
        repeat (5) @(negedge clk);
        checkOutput("stop_pres_valid", int'(out_valid), 1);
        checkOutput("stop_pres_busy", int'(busy), 1);
        checkOutput("stop_pres_nodone", n_done - s_done, 0);
        fixed_ready = 1'b1;
        waitIdle(50);
        checkRun("stop_pres", 1, 1, 0);

        // FREE_RUN, STOP accepted in WAIT after the first handshake
        snapshot();
        applyStimulus(OP_FREE, 14'd0, acc);
        for (int i = 0; i < 50 && n_hs == s_hs; i++) @(negedge clk);
        applyStimulus(OP_STOP, 14'd0, acc);
        repeat (3 * STEP_DIV) @(negedge clk);
        checkRun("stop_wait", 1, 1, 0);

        // Command while busy is dropped, run unaffected
        snapshot();
        applyStimulus(OP_RUN, 14'd3, acc);
        repeat (2) @(negedge clk);
        applyStimulus(OP_RUN, 14'd5, acc);
        waitIdle(100);
        checkRun("busy_cmd", 3, 1, 1);

        // Randomised seeds, run lengths and backpressure
        for (int it = 0; it < 6; it++) begin
            seed = WIDTH'($urandom_range(0, 16383));
            if (it == 0) seed = '0;
            applyStimulus(OP_LOAD, seed, acc);
            waitIdle(20);
            checkOutput($sformatf("rnd%0d_seed", it), last_seed, (seed == '0) ? 1 : int'(seed));
            model_state = (seed == '0) ? 14'h0001 : seed;
            n = int'($urandom_range(1, 5));
            snapshot();
            rand_en = 1'b1;
            applyStimulus(OP_RUN, WIDTH'(n), acc);
            waitIdle(400);
            rand_en = 1'b0;
            checkRun($sformatf("rnd%0d", it), n, 1, 0);
        end

        checkOutput("protocol_violations", viol, 0);

        // Reset mid-run discards the pending output
        fixed_ready = 1'b0;
        applyStimulus(OP_RUN, 14'd5, acc);
        waitValid(50);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", int'(out_valid), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_cmd_ready", int'(cmd_ready), 1);
        checkOutput("midrst_step_cnt", int'(step_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got 1 expected 0");
        $fatal(1, "[TB] global timeout");
    end

endmodule
